sme_load_buffer: RTL

Parametrised front-end buffer for the string-matching engine. Captures string and pattern bytes from a byte-serial write port into flat registers. When the load ends, it computes the KMP failure function of the pattern with an internal sequential engine, then pulses `valid`. It supersedes the fixed-size loader and drives the matcher core with the same flat-bus style, adding:

- length counts
- overflow detection
- load abort/restart
- a built-in failure-function engine

---
 rtl/sme_load_buffer.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/sme_load_buffer.sv
`default_nettype none
// ============================================================================
// sme_load_buffer : byte-serial string/pattern loader with KMP failure engine
// Revision 1.0
// ============================================================================
module sme_load_buffer #(
  parameter int BYTE_W  = 8,
  parameter int MAX_STR = 32,
  parameter int MAX_PAT = 8,
  parameter int STR_AW  = $clog2(MAX_STR),
  parameter int PAT_AW  = $clog2(MAX_PAT)
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [BYTE_W-1:0]           w_data,
  input  logic                        write,
  input  logic                        w_sel,
  output logic [MAX_STR*BYTE_W-1:0]   str_reg,
  output logic [MAX_PAT*BYTE_W-1:0]   pat_reg,
  output logic [STR_AW:0]             str_len,
  output logic [PAT_AW:0]             pat_len,
  output logic [MAX_PAT*PAT_AW-1:0]   ff_result,
  output logic                        valid,
  output logic                        busy,
  output logic                        overflow
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_LOAD    = 3'd1;
  localparam logic [2:0] S_FF_INIT = 3'd2;
  localparam logic [2:0] S_FF_RUN  = 3'd3;
  localparam logic [2:0] S_DONE    = 3'd4;

  localparam logic [STR_AW:0] C_STR_CAP = (STR_AW+1)'(MAX_STR);
  localparam logic [PAT_AW:0] C_PAT_CAP = (PAT_AW+1)'(MAX_PAT);
  localparam logic [PAT_AW:0] C_PAT_ONE = (PAT_AW+1)'(1);

  logic [2:0]        r_state;
  logic [2:0]        w_next_state;
  logic [PAT_AW-1:0] r_i;
  logic [PAT_AW-1:0] r_k;
  logic [PAT_AW-1:0] r_ff [MAX_PAT];

  logic w_new_load;
  logic w_load_wr;
  logic w_match;
  logic w_advance;
  logic w_last;

  // Any write outside LOAD starts a fresh load, aborting a pending computation.
  assign w_new_load = write && (r_state != S_LOAD);
  assign w_load_wr  = write && (r_state == S_LOAD);
  assign w_match    = pat_reg[r_i*BYTE_W +: BYTE_W] == pat_reg[r_k*BYTE_W +: BYTE_W];
  assign w_advance  = w_match || (r_k == '0);
  assign w_last     = ({1'b0, r_i} + C_PAT_ONE) == pat_len;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    if (w_new_load) begin
      w_next_state = S_LOAD;
    end else begin
      case (r_state)
        S_IDLE:    w_next_state = S_IDLE;
        S_LOAD:    if (!write) w_next_state = S_FF_INIT;
        S_FF_INIT: w_next_state = (pat_len <= C_PAT_ONE) ? S_DONE : S_FF_RUN;
        S_FF_RUN:  if (w_advance && w_last) w_next_state = S_DONE;
        S_DONE:    w_next_state = S_IDLE;
        default:   w_next_state = S_IDLE;
      endcase
    end
  end

  always_comb begin
    busy  = (r_state != S_IDLE);
    valid = (r_state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      str_reg  <= '0;
      pat_reg  <= '0;
      str_len  <= '0;
      pat_len  <= '0;
      overflow <= 1'b0;
      r_i      <= '0;
      r_k      <= '0;
      for (int n = 0; n < MAX_PAT; n++) begin
        r_ff[n] <= '0;
      end
    end else if (w_new_load) begin
      overflow <= 1'b0;
      if (w_sel) begin
        pat_reg[0 +: BYTE_W] <= w_data;
        pat_len              <= C_PAT_ONE;
        str_len              <= '0;
      end else begin
        str_reg[0 +: BYTE_W] <= w_data;
        str_len              <= (STR_AW+1)'(1);
        pat_len              <= '0;
      end
    end else if (w_load_wr) begin
      if (w_sel) begin
        if (pat_len == C_PAT_CAP) begin
          overflow <= 1'b1;
        end else begin
          pat_reg[pat_len[PAT_AW-1:0]*BYTE_W +: BYTE_W] <= w_data;
          pat_len <= pat_len + 1'b1;
        end
      end else begin
        if (str_len == C_STR_CAP) begin
          overflow <= 1'b1;
        end else begin
          str_reg[str_len[STR_AW-1:0]*BYTE_W +: BYTE_W] <= w_data;
          str_len <= str_len + 1'b1;
        end
      end
    end else begin
      case (r_state)
        S_FF_INIT: begin
          for (int n = 0; n < MAX_PAT; n++) begin
            r_ff[n] <= '0;
          end
          r_i <= PAT_AW'(1);
          r_k <= '0;
        end
        S_FF_RUN: begin
          if (w_match) begin
            r_ff[r_i] <= r_k + 1'b1;
            r_k       <= r_k + 1'b1;
            r_i       <= r_i + 1'b1;
          end else if (r_k != '0) begin
            // Fall back to the longest proper border; i stays put.
            r_k <= r_ff[r_k - 1'b1];
          end else begin
            r_ff[r_i] <= '0;
            r_i       <= r_i + 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  generate
    for (genvar g = 0; g < MAX_PAT; g++) begin : g_ff_pack
      assign ff_result[g*PAT_AW +: PAT_AW] = r_ff[g];
    end
  endgenerate

endmodule
`default_nettype wire
